// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified code/data memory port.
// Owner encoding and word geometry.
package riscv_mem_pkg;

    localparam int WORD_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between fetch and data.
// Data wins unless its burst has run out while fetch waits.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic               I_REQ,
    input  logic               D_REQ,
    input  logic [BURST_W-1:0] d_burst,
    output logic               gnt_i,
    output logic               gnt_d
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

    logic d_win;
    logic i_win;

    assign d_win = D_REQ && !(I_REQ && (d_burst == BURST_MAX));
    assign i_win = I_REQ && !d_win;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (1'b1)
            d_win:   gnt_d = 1'b1;
            i_win:   gnt_i = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and data ports.
// Tracks response owner, data burst length and fetch stalls.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AWIDTH      = 12,
    parameter int MAX_D_BURST = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              I_REQ,
    input  logic [AWIDTH-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [WORD_W-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic [AWIDTH-1:0] D_ADDR,
    input  logic              D_WEN,
    input  logic [BE_W-1:0]   D_BE,
    input  logic [WORD_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [WORD_W-1:0] D_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [BE_W-1:0]   MEM_BE,
    output logic [AWIDTH-3:0] MEM_ADDR,
    output logic [WORD_W-1:0] MEM_DOUT,
    input  logic [WORD_W-1:0] MEM_DI,
    output logic [31:0]       I_STALL_CNT
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

    logic               gnt_i;
    logic               gnt_d;
    logic [BURST_W-1:0] d_burst;
    owner_e             owner;
    logic [AWIDTH-3:0]  addr_q;
    logic [WORD_W-1:0]  dout_q;
    logic [WORD_W-1:0]  i_rdata_q;
    logic [WORD_W-1:0]  d_rdata_q;
    logic [31:0]        stall_q;
    logic               unused_addr_lsb;

    // Byte lanes are resolved by BE, so the low address bits are dropped.
    assign unused_addr_lsb = ^{I_ADDR[1:0], D_ADDR[1:0]};

    mem_arb_pick #(
        .MAX_D_BURST(MAX_D_BURST)
    ) u_pick (
        .I_REQ  (I_REQ),
        .D_REQ  (D_REQ),
        .d_burst(d_burst),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    assign I_GNT = gnt_i & RSTn;
    assign D_GNT = gnt_d & RSTn;

    always_comb begin
        MEM_CSN  = 1'b1;
        MEM_WEN  = 1'b1;
        MEM_BE   = '0;
        MEM_ADDR = addr_q;
        MEM_DOUT = dout_q;
        unique case (1'b1)
            D_GNT: begin
                MEM_CSN  = 1'b0;
                MEM_WEN  = D_WEN;
                MEM_BE   = D_BE;
                MEM_ADDR = D_ADDR[AWIDTH-1:2];
                MEM_DOUT = D_WDATA;
            end
            I_GNT: begin
                MEM_CSN  = 1'b0;
                MEM_BE   = '1;
                MEM_ADDR = I_ADDR[AWIDTH-1:2];
            end
            default: ;
        endcase
    end

    assign I_RVALID    = (owner == OWN_I);
    assign D_RVALID    = (owner == OWN_D);
    assign I_RDATA     = I_RVALID ? MEM_DI : i_rdata_q;
    assign D_RDATA     = D_RVALID ? MEM_DI : d_rdata_q;
    assign I_STALL_CNT = stall_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            owner     <= OWN_NONE;
            d_burst   <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            stall_q   <= '0;
        end else begin
            addr_q <= MEM_ADDR;
            dout_q <= MEM_DOUT;
            if (D_GNT) begin
                owner <= OWN_D;
            end else if (I_GNT) begin
                owner <= OWN_I;
            end else begin
                owner <= OWN_NONE;
            end
            if (I_RVALID) begin
                i_rdata_q <= MEM_DI;
            end
            if (D_RVALID) begin
                d_rdata_q <= MEM_DI;
            end
            // Burst only matters while fetch is actually waiting.
            if (!I_REQ || I_GNT) begin
                d_burst <= '0;
            end else if (D_GNT && (d_burst != BURST_MAX)) begin
                d_burst <= d_burst + 1'b1;
            end
            if (I_REQ && !I_GNT) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

endmodule
